// File: rtl/aes_pkg.sv
// AES shared definitions: state geometry, byte type, FSM encoding and the
// S-box constant tables. The inverse table exists only when SUB_BYTES_INV_EN
// is defined.
package aes_pkg;

  localparam int AES_STATE_W   = 128;
  localparam int AES_NUM_BYTES = 16;

  typedef logic [7:0] aes_byte_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } sb_state_e;

  localparam aes_byte_t SBOX_FWD [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

`ifdef SUB_BYTES_INV_EN
  localparam aes_byte_t SBOX_INV [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };
`endif

endpackage

// File: rtl/aes_sbox.sv
// Single combinational S-box lane. Forward lookup always; with
// SUB_BYTES_INV_EN defined it also holds the inverse table and an inv select.
module aes_sbox
  import aes_pkg::*;
(
  input  aes_byte_t byte_i,
`ifdef SUB_BYTES_INV_EN
  input  logic      inv_i,
`endif
  output aes_byte_t byte_o
);

`ifdef SUB_BYTES_INV_EN
  assign byte_o = inv_i ? SBOX_INV[byte_i] : SBOX_FWD[byte_i];
`else
  assign byte_o = SBOX_FWD[byte_i];
`endif

endmodule

// File: rtl/sub_bytes_iter.sv
// Iterative AES SubBytes engine: one 128-bit state in, BYTES_PER_CYCLE bytes
// substituted per BUSY cycle (lowest byte index first), result held in DONE
// until taken. Optional SUB_BYTES_INV_EN adds an inv port that selects the
// inverse S-box for the whole operation.
module sub_bytes_iter
  import aes_pkg::*;
#(
  parameter int BYTES_PER_CYCLE = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AES_STATE_W-1:0] in_state,
`ifdef SUB_BYTES_INV_EN
  input  logic                   inv,
`endif
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AES_STATE_W-1:0] out_state
);

  localparam int BEATS = AES_NUM_BYTES / BYTES_PER_CYCLE;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  generate
    if (!(BYTES_PER_CYCLE == 1 || BYTES_PER_CYCLE == 2 || BYTES_PER_CYCLE == 4 ||
          BYTES_PER_CYCLE == 8 || BYTES_PER_CYCLE == 16)) begin : g_bad_bpc
      $error("sub_bytes_iter: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end
  endgenerate

  sb_state_e                          state_q, state_d;
  logic      [CNT_W-1:0]              cnt_q, cnt_d;
  aes_byte_t [AES_NUM_BYTES-1:0]      work_q, work_d;
  aes_byte_t [BYTES_PER_CYCLE-1:0]    lane_in, lane_out;
  logic      [3:0]                    base;
`ifdef SUB_BYTES_INV_EN
  logic                               inv_q, inv_d;
`endif

  // First byte index handled this beat; truncation is harmless because the
  // product never exceeds 15 for a legal configuration.
  assign base = 4'(cnt_q) * 4'(BYTES_PER_CYCLE);

  for (genvar l = 0; l < BYTES_PER_CYCLE; l++) begin : g_lane
    assign lane_in[l] = work_q[base + 4'(l)];
    aes_sbox u_sbox (
      .byte_i (lane_in[l]),
`ifdef SUB_BYTES_INV_EN
      .inv_i  (inv_q),
`endif
      .byte_o (lane_out[l])
    );
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign out_state = work_q;

  // Next-state, beat counter and in-place byte substitution.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
`ifdef SUB_BYTES_INV_EN
    inv_d   = inv_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          work_d  = in_state;
          cnt_d   = '0;
`ifdef SUB_BYTES_INV_EN
          inv_d   = inv;
`endif
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        for (int l = 0; l < BYTES_PER_CYCLE; l++) begin
          work_d[base + 4'(l)] = lane_out[l];
        end
        // Counter parks on the last beat rather than wrapping.
        if (cnt_q == LAST_BEAT) state_d = ST_DONE;
        else                    cnt_d   = cnt_q + 1'b1;
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register; reset discards any partial or pending result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
`ifdef SUB_BYTES_INV_EN
      inv_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
`ifdef SUB_BYTES_INV_EN
      inv_q   <= inv_d;
`endif
    end
  end

endmodule

// File: tb/tb_sub_bytes_iter.sv
// Directed bench for sub_bytes_iter. Instance index 2 (BYTES_PER_CYCLE=4) is
// the main DUT; the others share its inputs and are used for latency sweeps.
`timescale 1ns/1ps
module tb_sub_bytes_iter;

  localparam int BPC_TAB [5] = '{1, 2, 4, 8, 16};
  localparam int LAT_TAB [5] = '{17, 9, 5, 3, 2};

  localparam logic [127:0] FIPS_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] FIPS_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;
  localparam logic [127:0] ALL_00   = {16{8'h00}};
  localparam logic [127:0] ALL_63   = {16{8'h63}};
  localparam logic [127:0] ALL_01   = {16{8'h01}};
  localparam logic [127:0] ALL_7C   = {16{8'h7c}};
  localparam logic [127:0] ALL_FF   = {16{8'hff}};
  localparam logic [127:0] ALL_16   = {16{8'h16}};
  localparam logic [127:0] ALL_53   = {16{8'h53}};
  localparam logic [127:0] ALL_ED   = {16{8'hed}};

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         out_ready;
  logic [127:0] in_state;
`ifdef SUB_BYTES_INV_EN
  logic         inv;
`endif
  logic [4:0]   ir, ov;
  logic [127:0] os [5];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar i = 0; i < 5; i++) begin : g_dut
    sub_bytes_iter #(.BYTES_PER_CYCLE(BPC_TAB[i])) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (ir[i]),
      .in_state  (in_state),
`ifdef SUB_BYTES_INV_EN
      .inv       (inv),
`endif
      .out_valid (ov[i]),
      .out_ready ((i == 2) ? out_ready : 1'b1),
      .out_state (os[i])
    );
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One transaction on the main DUT with out_ready=1; returns the result, the
  // cycle out_valid was first seen (accept cycle = 0) and ends back in IDLE.
  task automatic run_tx(input logic [127:0] st, output logic [127:0] res, output int lat);
    res      = '0;
    lat      = 0;
    in_state = st;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int c = 1; c <= 40 && lat == 0; c++) begin
      if (ov[2]) begin
        lat = c;
        res = os[2];
      end else begin
        tick();
      end
    end
    if (lat != 0) tick();
  endtask

  initial begin
    logic [127:0] res;
    int           lat;
    int           flat [5];
    logic [127:0] fres [5];
    logic [127:0] bres [2];
    int           bcyc [2];
    int           nres;
    logic         hs_pending;
    logic         saw;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    in_state  = '0;
`ifdef SUB_BYTES_INV_EN
    inv       = 1'b0;
`endif
    repeat (3) tick();
    chk("rst_in_ready",  128'(ir[2]), 128'(1'b1));
    chk("rst_out_valid", 128'(ov[2]), 128'(1'b0));
    chk("rst_out_state", os[2], ALL_00);
    rst = 1'b0;
    tick();

    // FIPS vector through every lane count at once.
    for (int i = 0; i < 5; i++) begin flat[i] = 0; fres[i] = '0; end
    in_state = FIPS_IN;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      for (int i = 0; i < 5; i++) begin
        if (ov[i] && flat[i] == 0) begin
          flat[i] = c;
          fres[i] = os[i];
        end
      end
      tick();
    end
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("fips_lat_bpc%0d", BPC_TAB[i]), 128'(flat[i]), 128'(LAT_TAB[i]));
      chk($sformatf("fips_data_bpc%0d", BPC_TAB[i]), fres[i], FIPS_OUT);
    end

    // All-zero state, single-cycle out_valid.
    run_tx(ALL_00, res, lat);
    chk("zero_data", res, ALL_63);
    chk("zero_lat", 128'(lat), 128'(5));
    chk("zero_valid_drop", 128'(ov[2]), 128'(1'b0));
    chk("zero_ready_back", 128'(ir[2]), 128'(1'b1));

    run_tx(ALL_FF, res, lat);
    chk("ff_data", res, ALL_16);

    // Backpressure: result held stable, no new accept.
    out_ready = 1'b0;
    in_state  = ALL_01;
    in_valid  = 1'b1;
    tick();
    in_valid  = 1'b0;
    lat = 0;
    for (int c = 1; c <= 40 && lat == 0; c++) begin
      if (ov[2]) lat = c;
      else tick();
    end
    chk("bp_lat", 128'(lat), 128'(5));
    chk("bp_data", os[2], ALL_7C);
    in_state = ALL_53;
    in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("bp_hold_state", os[2], ALL_7C);
      chk("bp_hold_in_ready", 128'(ir[2]), 128'(1'b0));
      chk("bp_hold_out_valid", 128'(ov[2]), 128'(1'b1));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp_release_valid", 128'(ov[2]), 128'(1'b0));
    chk("bp_release_ready", 128'(ir[2]), 128'(1'b1));
    tick();
    chk("bp_release_idle", 128'(ir[2]), 128'(1'b1));

    // Reset mid-BUSY, with in_valid asserted alongside reset.
    in_state = ALL_FF;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst      = 1'b1;
    in_valid = 1'b1;
    in_state = ALL_53;
    tick();
    chk("midrst_in_ready",  128'(ir[2]), 128'(1'b1));
    chk("midrst_out_valid", 128'(ov[2]), 128'(1'b0));
    chk("midrst_out_state", os[2], ALL_00);
    rst      = 1'b0;
    in_valid = 1'b0;
    saw = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (ov[2]) saw = 1'b1;
      tick();
    end
    chk("midrst_no_result", 128'(saw), 128'(1'b0));
    run_tx(ALL_53, res, lat);
    chk("after_rst_data", res, ALL_ED);
    chk("after_rst_lat", 128'(lat), 128'(5));

    // in_valid held with a different state during BUSY.
    nres = 0;
    bres[0] = '0; bres[1] = '0; bcyc[0] = 0; bcyc[1] = 0;
    in_state   = FIPS_IN;
    in_valid   = 1'b1;
    hs_pending = 1'b0;
    for (int c = 1; c <= 40 && nres < 2; c++) begin
      tick();
      if (c == 1) in_state = ALL_00;
      if (hs_pending) in_valid = 1'b0;
      if (ov[2]) begin
        bres[nres] = os[2];
        bcyc[nres] = c;
        nres++;
      end
      hs_pending = in_valid && ir[2];
    end
    in_valid = 1'b0;
    chk("busy_in_first_data", bres[0], FIPS_OUT);
    chk("busy_in_first_cyc", 128'(bcyc[0]), 128'(5));
    chk("busy_in_second_data", bres[1], ALL_63);
    chk("busy_in_second_cyc", 128'(bcyc[1]), 128'(11));
    repeat (3) tick();

`ifdef SUB_BYTES_INV_EN
    inv = 1'b1;
    run_tx(ALL_63, res, lat);
    chk("inv_63", res, ALL_00);
    run_tx(FIPS_OUT, res, lat);
    chk("inv_fips", res, FIPS_IN);
    inv = 1'b0;
    run_tx(FIPS_IN, res, lat);
    chk("fwd_fips_inv_build", res, FIPS_OUT);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
